// File: rtl/sync_recover_213.sv
// sync_recover_213: resync controller for the (2,1,3) Viterbi decoder.
// Integrates error pulses per window, slips symbol alignment on loss of sync.
// Ports: clock, reset (sync, active-high), we (symbol strobe), error (detector
//   pulse) -> slip, dec_clear (1-cycle pulses), locked, slip_count[7:0].
// Optional: define SYNC_RECOVER_STATS_EN to implement the slip_count register;
//   otherwise slip_count is tied to 0.
module sync_recover_213 #(
  parameter int unsigned WINDOW  = 16,
  parameter int unsigned THRESH  = 4,
  parameter int unsigned HOLDOFF = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       we,
  input  logic       error,
  output logic       slip,
  output logic       dec_clear,
  output logic       locked,
  output logic [7:0] slip_count
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCK   = 2'd1,
    SLIP   = 2'd2,
    SETTLE = 2'd3
  } state_t;

  localparam logic [7:0] WIN_LAST = 8'(WINDOW - 1);
  localparam logic [7:0] HOLD_LIM = 8'(HOLDOFF);
  localparam logic [8:0] THR      = 9'(THRESH);

  state_t     state;
  state_t     state_nx;
  logic [7:0] win_cnt;
  logic [7:0] win_nx;
  logic [7:0] err_cnt;
  logic [7:0] err_nx;
  logic [7:0] good_cnt;
  logic [7:0] good_nx;
  logic [7:0] hold_cnt;
  logic [7:0] hold_nx;

  logic       win_end;
  logic [8:0] err_total;
  logic       bad;
  logic [7:0] err_inc;
  logic [7:0] hold_inc;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= SEARCH;
      win_cnt  <= '0;
      err_cnt  <= '0;
      good_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      win_cnt  <= win_nx;
      err_cnt  <= err_nx;
      good_cnt <= good_nx;
      hold_cnt <= hold_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    win_nx    = win_cnt;
    err_nx    = err_cnt;
    good_nx   = good_cnt;
    hold_nx   = hold_cnt;
    win_end   = we && (win_cnt == WIN_LAST);
    // an error on the window-end cycle belongs to the ending window
    err_total = {1'b0, err_cnt} + {8'd0, error};
    bad       = (err_total >= THR);
    err_inc   = (err_cnt == 8'hff) ? err_cnt
                                   : err_cnt + {7'd0, error};
    hold_inc  = hold_cnt + 8'd1;

    unique case (state)
      SEARCH, LOCK: begin
        // detector lags we by a cycle, so errors count regardless of we
        err_nx = err_inc;
        if (we) win_nx = win_cnt + 8'd1;
        if (win_end) begin
          win_nx = '0;
          err_nx = '0;
          if (bad) begin
            state_nx = SLIP;
            good_nx  = '0;
          end else if (state == SEARCH) begin
            if (good_cnt == 8'd1) begin
              state_nx = LOCK;
              good_nx  = '0;
            end else begin
              good_nx = good_cnt + 8'd1;
            end
          end
        end
      end
      SLIP: begin
        state_nx = SETTLE;
        win_nx   = '0;
        err_nx   = '0;
        good_nx  = '0;
        hold_nx  = '0;
      end
      SETTLE: begin
        err_nx = '0;
        if (HOLDOFF == 0) begin
          state_nx = SEARCH;
          win_nx   = '0;
        end else if (we) begin
          hold_nx = hold_inc;
          if (hold_inc == HOLD_LIM) begin
            state_nx = SEARCH;
            win_nx   = '0;
          end
        end
      end
      default: begin
        state_nx = SEARCH;
      end
    endcase
  end

  // outputs are registered copies of the next-state decode
  always_ff @(posedge clock) begin
    if (reset) begin
      slip      <= 1'b0;
      dec_clear <= 1'b0;
      locked    <= 1'b0;
    end else begin
      slip      <= (state_nx == SLIP);
      dec_clear <= (state_nx == SLIP);
      locked    <= (state_nx == LOCK);
    end
  end

`ifdef SYNC_RECOVER_STATS_EN
  logic [7:0] slips;

  always_ff @(posedge clock) begin
    if (reset) begin
      slips <= '0;
    end else if (state_nx == SLIP && slips != 8'hff) begin
      slips <= slips + 8'd1;
    end
  end

  assign slip_count = slips;
`else
  assign slip_count = 8'd0;
`endif

endmodule

// File: tb/tb_sync_recover_213.sv
// tb_sync_recover_213: directed table-driven bench for sync_recover_213.
// Main instance W=8/T=3/H=4; second instance W=1/T=1/H=0 for slip rate.
module tb_sync_recover_213;

  typedef struct {
    logic rst;
    logic we;
    logic err;
    logic slip;
    logic lock;
    int   cnt;
  } vec_t;

  logic       clock;
  logic       reset;
  logic       we;
  logic       error;
  logic       slip;
  logic       dec_clear;
  logic       locked;
  logic [7:0] slip_count;

  logic       reset2;
  logic       we2;
  logic       error2;
  logic       slip2;
  logic       dec_clear2;
  logic       locked2;
  logic [7:0] slip_count2;

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  sync_recover_213 #(.WINDOW(8), .THRESH(3), .HOLDOFF(4)) dut (
    .clock(clock), .reset(reset), .we(we), .error(error),
    .slip(slip), .dec_clear(dec_clear), .locked(locked),
    .slip_count(slip_count)
  );

  sync_recover_213 #(.WINDOW(1), .THRESH(1), .HOLDOFF(0)) dut2 (
    .clock(clock), .reset(reset2), .we(we2), .error(error2),
    .slip(slip2), .dec_clear(dec_clear2), .locked(locked2),
    .slip_count(slip_count2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int expc(int c);
`ifdef SYNC_RECOVER_STATS_EN
    return c;
`else
    return 0;
`endif
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(logic r, logic w, logic e,
                     logic s, logic l, int c);
    vec_t v;
    v.rst = r; v.we = w; v.err = e;
    v.slip = s; v.lock = l; v.cnt = c;
    vecs.push_back(v);
  endtask

  task automatic step(logic r, logic w, logic e);
    @(negedge clock);
    reset = r; we = w; error = e;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(string name, logic s, logic l, int c);
    chk({name, ".slip"}, int'(slip), int'(s));
    chk({name, ".clr"}, int'(dec_clear), int'(s));
    chk({name, ".lock"}, int'(locked), int'(l));
    chk({name, ".cnt"}, int'(slip_count), expc(c));
  endtask

  initial begin
    int nslip;
    reset = 1'b1; we = 1'b0; error = 1'b0;
    reset2 = 1'b1; we2 = 1'b1; error2 = 1'b1;

    add(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 16; i++)
      add(0, 1, 0, 0, i == 16, 0);
    for (int i = 17; i <= 24; i++)
      add(0, 1, i == 18 || i == 20 || i == 22,
          i == 24, i < 24, i == 24 ? 1 : 0);
    add(0, 1, 0, 0, 0, 1);
    for (int i = 26; i <= 29; i++)
      add(0, 1, 1, 0, 0, 1);
    for (int i = 30; i <= 37; i++)
      add(0, 1, i == 31 || i == 33, 0, 0, 1);
    for (int i = 38; i <= 45; i++) begin
      add(0, 1, i == 39 || i == 45, i == 45, 0,
          i == 45 ? 2 : 1);
      if (i == 40) add(0, 0, 1, 0, 0, 1);
    end
    add(0, 1, 0, 0, 0, 2);

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].we, vecs[k].err);
      chk_out($sformatf("vec%0d", k), vecs[k].slip,
              vecs[k].lock, vecs[k].cnt);
    end

    // reset while SLIP is showing drops the pulse
    step(1, 0, 0);
    chk_out("rst0", 0, 0, 0);
    for (int i = 1; i <= 8; i++) step(0, 1, 1);
    chk_out("bad_win", 1, 0, 1);
    step(1, 1, 1);
    chk_out("rst_in_slip", 0, 0, 0);
    for (int i = 1; i <= 15; i++) step(0, 1, 0);
    chk_out("relock15", 0, 0, 0);
    step(0, 1, 0);
    chk_out("relock16", 0, 1, 0);

    // fastest config: slip every 3 cycles, counter saturates
    @(negedge clock);
    reset2 = 1'b0;
    nslip = 0;
    for (int k = 1; k <= 800; k++) begin
      @(posedge clock);
      #1;
      if (slip2) nslip++;
      if (k <= 9) begin
        chk($sformatf("fast_slip%0d", k), int'(slip2),
            int'(k % 3 == 1));
        chk($sformatf("fast_clr%0d", k), int'(dec_clear2),
            int'(k % 3 == 1));
      end
    end
    chk("fast_total", nslip, 267);
    chk("fast_sat", int'(slip_count2), expc(255));
    chk("fast_lock", int'(locked2), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
